// File: rtl/raster_scan_ctrl_if.sv
// Stream and control bundle for raster_scan_ctrl: frame config/start/abort
// toward the sequencer, coordinate beats and status back from it.
interface raster_scan_ctrl_if #(
    parameter int unsigned width_p       = 10,
    parameter int unsigned blank_width_p = 8
);
    logic                     start_i;
    logic                     abort_i;
    logic [width_p-1:0]       cols_i;
    logic [width_p-1:0]       rows_i;
    logic [blank_width_p-1:0] hblank_i;
    logic                     ready_i;
    logic                     valid_o;
    logic [width_p-1:0]       x_o;
    logic [width_p-1:0]       y_o;
    logic                     sof_o;
    logic                     eol_o;
    logic                     eof_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, abort_i, cols_i, rows_i, hblank_i, ready_i,
        input  valid_o, x_o, y_o, sof_o, eol_o, eof_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, cols_i, rows_i, hblank_i, ready_i,
        output valid_o, x_o, y_o, sof_o, eol_o, eof_o, busy_o, done_o
    );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Raster scan sequencer: walks (x,y) over a latched frame geometry, one
// coordinate beat per valid/ready handshake, with optional blanking between
// lines, abort, and a one-cycle done pulse. Outputs decode registered state
// only, so ready_i never reaches valid_o combinationally.
module raster_scan_ctrl #(
    parameter int unsigned width_p       = 10,
    parameter int unsigned blank_width_p = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    raster_scan_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, DONE} state_e;

    localparam logic [width_p-1:0]       XONE = width_p'(1);
    localparam logic [blank_width_p-1:0] BONE = blank_width_p'(1);

    state_e                   state_q, state_d;
    logic [width_p-1:0]       x_q, x_d, y_q, y_d;
    logic [width_p-1:0]       cols_q, cols_d, rows_q, rows_d;
    logic [blank_width_p-1:0] blank_q, blank_d, hblank_q, hblank_d;

    logic last_col, last_row, blank_last;

    assign last_col   = (x_q == cols_q);
    assign last_row   = (y_q == rows_q);
    assign blank_last = (blank_q == hblank_q - BONE);

    // State, counters and latched geometry registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            blank_q  <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            hblank_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            blank_q  <= blank_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            hblank_q <= hblank_d;
        end
    end

    // Next-state and counter update; abort overrides everything last
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        blank_d  = blank_q;
        cols_d   = cols_q;
        rows_d   = rows_q;
        hblank_d = hblank_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    cols_d   = bus.cols_i;
                    rows_d   = bus.rows_i;
                    hblank_d = bus.hblank_i;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.ready_i) begin
                    if (!last_col) begin
                        x_d = x_q + XONE;
                    end else if (!last_row) begin
                        x_d     = '0;
                        y_d     = y_q + XONE;
                        state_d = (hblank_q != '0) ? HBLANK : ACTIVE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HBLANK: begin
                if (blank_last) begin
                    blank_d = '0;
                    state_d = ACTIVE;
                end else begin
                    blank_d = blank_q + BONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.abort_i) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            blank_d = '0;
        end
    end

    // State-decoded outputs
    always_comb begin
        bus.valid_o = (state_q == ACTIVE);
        bus.x_o     = x_q;
        bus.y_o     = y_q;
        bus.sof_o   = bus.valid_o && (x_q == '0) && (y_q == '0);
        bus.eol_o   = bus.valid_o && last_col;
        bus.eof_o   = bus.valid_o && last_col && last_row;
        bus.busy_o  = (state_q != IDLE);
        bus.done_o  = (state_q == DONE);
    end
endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Sequencer that walks a two-level rolling column/row count across a configurable frame and presents each pixel coordinate on a valid/ready stream. It sits between the camera/frame-buffer front end and downstream pixel consumers (readout, filters, DMA), providing coordinates plus start-of-frame, end-of-line and end-of-frame markers. It supports inter-line blanking, abort, and a one-cycle completion pulse.

## Interface
- width_p, 10, width of coordinate counters and frame-size inputs
- blank_width_p, 8, width of the horizontal-blanking cycle count
- clk_i  input  1  single clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  begin a frame; honoured only in IDLE
- abort_i  input  1  terminate current frame, return to IDLE
- cols_i  input  width_p  last column index (frame width − 1), sampled at start
- rows_i  input  width_p  last row index (frame height − 1), sampled at start
- hblank_i  input  blank_width_p  idle cycles inserted after each non-final line, sampled at start
- ready_i  input  1  downstream accepts current beat
- valid_o  output  1  x_o/y_o and markers are valid
- x_o  output  width_p  current column
- y_o  output  width_p  current row
- sof_o  output  1  valid_o & x_o==0 & y_o==0
- eol_o  output  1  valid_o & x_o==cols_r
- eof_o  output  1  eol_o & y_o==rows_r
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, ACTIVE, HBLANK, DONE.
- Reset (async assert): state IDLE, x/y/blank counters 0, latched config 0; all outputs 0.
- IDLE: start_i=1 latches cols_i/rows_i/hblank_i into cols_r/rows_r/hblank_r, clears x/y, next state ACTIVE. Config inputs are ignored at all other times.
- ACTIVE: valid_o=1. A beat is transferred on valid_o & ready_i.
  - x<cols_r: x increments.
  - x==cols_r and y<rows_r: x←0, y increments. Next state is HBLANK if hblank_r≠0, else it stays ACTIVE.
  - x==cols_r and y==rows_r: next state DONE. x and y hold.
- No transfer: x, y and all outputs hold stable.
- HBLANK: valid_o=0. The blank counter counts 0..hblank_r−1, so the block spends exactly hblank_r cycles here, then returns to ACTIVE. The blank counter clears on exit.
- DONE: done_o=1 for exactly one cycle, valid_o=0, then IDLE.
- abort_i=1 in any state: next state IDLE, x/y/blank counters cleared, no done_o pulse. Abort has priority over start_i and over a simultaneous transfer. A beat handshaked in the abort cycle counts as delivered, but the frame is still abandoned.
- start_i in ACTIVE/HBLANK/DONE is ignored; it is not queued.
- Counter arithmetic is unsigned, width_p bits. The comparisons use the latched cols_r/rows_r, so no overflow is possible.

## Timing
- start_i sampled high at edge N gives valid_o=1 with sof_o=1 from N+1.
- Throughput is one beat per cycle while ready_i=1.
- Full frame with ready_i held high: (cols+1)(rows+1) ACTIVE cycles, plus rows·hblank HBLANK cycles, plus 1 DONE cycle.
- done_o asserts the cycle after the eof_o beat is accepted. busy_o drops the cycle after that.
- A start_i during the DONE cycle is ignored. Earliest restart is start_i sampled in the first IDLE cycle.
- Degenerate case cols=0, rows=0: one beat with sof_o, eol_o and eof_o all high, then DONE.
- The valid_o/x_o/y_o markers are registered/state-decoded: no combinational path from ready_i to valid_o.

## Test plan
- Basic frame, cols=3, rows=2, hblank=0, ready=1:
  - 12 consecutive beats in raster order (0,0)…(3,2).
  - sof_o on beat 0; eol_o on beats 3, 7, 11; eof_o on beat 11.
  - done_o one cycle later; busy_o spans 13 cycles.
- Blanking, cols=1, rows=1, hblank=3: beats (0,0),(1,0), then 3 cycles valid_o=0, then (0,1),(1,1), then done_o.
- Backpressure: random ready_i on a cols=4, rows=3 frame. x_o/y_o never change while valid_o & !ready_i, the 20-beat sequence is still exact, and done_o is a single pulse.
- Abort mid-line at (2,1), with ready_i=1 in the same cycle:
  - Next cycle is IDLE, busy_o=0, valid_o=0, and done_o never fires.
  - A new start_i gives sof_o at (0,0).
- Config isolation and start-ignore:
  - Change cols_i/rows_i and pulse start_i mid-frame. Frame geometry is unchanged and no second frame begins.
  - Degenerate cols=0, rows=0 gives one beat with sof/eol/eof all high.
- Async reset asserted mid-HBLANK, no clock edge: all outputs 0 immediately. After release, the block stays IDLE until start_i.
